bist_control: RTL and testbench

- Sequencer for a BIST session around a pattern-generator LFSR and a signature register.
- After a start request it runs four test sessions: every combination of 2 polynomials × 2 seeds, each session applying N_PATTERNS patterns.
- It drives the poly/seed selects, a test-mode enable, an end-of-test pulse and a sticky finished flag.
- Sits between the top-level test access logic and the LFSR/MISR datapath.

---
 rtl/bist_pkg.sv | 16 +
 rtl/bist_control_if.sv | 30 +++
 rtl/bist_edge_detect.sv | 21 ++
 rtl/bist_control.sv | 91 +++++++++
 tb/tb_bist_control.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST session sequencer.
// Imported by the controller and its sub-blocks.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        END,
        DONE
    } state_t;

    localparam int N_SESSIONS = 4;
    localparam int SESS_W     = 2;

endpackage

// File: rtl/bist_control_if.sv
// Test-access side bundle of the BIST sequencer: start request plus
// select, enable and completion signals toward the LFSR/MISR datapath.
interface bist_control_if;

    logic start;
    logic OUT;
    logic BIST_END;
    logic Poly;
    logic Seed;
    logic FINISH;

    modport master (
        output start,
        input  OUT,
        input  BIST_END,
        input  Poly,
        input  Seed,
        input  FINISH
    );

    modport slave (
        input  start,
        output OUT,
        output BIST_END,
        output Poly,
        output Seed,
        output FINISH
    );

endinterface

// File: rtl/bist_edge_detect.sv
// Rising-edge detector for the start request. Resets the history bit
// high so a level already asserted at reset release is not an edge.
module bist_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic rise
);

    logic start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            start_q <= 1'b1;
        else
            start_q <= start;
    end

    assign rise = start & ~start_q;

endmodule

// File: rtl/bist_control.sv
// BIST sequencer: four sessions (2 polys x 2 seeds) of N_PATTERNS
// patterns each, with end-of-test pulse and sticky finished flag.
module bist_control
    import bist_pkg::*;
#(
    parameter int N_PATTERNS = 16,
    parameter int CNT_W      = 12
) (
    input  logic           clk,
    input  logic           rst,
    bist_control_if.slave  bus
);

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(N_PATTERNS - 1);
    localparam logic [SESS_W-1:0] LAST_SESS = SESS_W'(N_SESSIONS - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SESS_W-1:0]  sess, sess_n;
    logic               start_edge;

    bist_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .start (bus.start),
        .rise  (start_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sess  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sess  <= sess_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sess_n  = sess;
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    state_n = LOAD;
                    sess_n  = '0;
                end
            end
            LOAD: begin
                cnt_n   = '0;
                state_n = RUN;
            end
            RUN: begin
                // Counter holds on the last pattern; LOAD clears it.
                if (cnt == LAST_CNT) begin
                    if (sess == LAST_SESS) begin
                        state_n = END;
                    end else begin
                        sess_n  = sess + 1'b1;
                        state_n = LOAD;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            END: begin
                state_n = DONE;
            end
            DONE: begin
                if (start_edge) begin
                    state_n = LOAD;
                    sess_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Session index order (0,0),(0,1),(1,0),(1,1) maps onto {Poly,Seed}.
    assign bus.Poly     = sess[1];
    assign bus.Seed     = sess[0];
    assign bus.OUT      = (state == RUN);
    assign bus.BIST_END = (state == END);
    assign bus.FINISH   = (state == DONE);

endmodule

// File: tb/tb_bist_control.sv
// Directed bench for bist_control: cycle-indexed checkpoint table
// applied to full runs, plus reset and start-level corner sequences.
module tb_bist_control;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    bist_control_if bus ();

    bist_control #(
        .N_PATTERNS (16),
        .CNT_W      (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {OUT, BIST_END, Poly, Seed, FINISH}
    typedef struct {
        int         k;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [4:0] outs();
        return {bus.OUT, bus.BIST_END, bus.Poly, bus.Seed, bus.FINISH};
    endfunction

    task automatic check(input string name, input logic [4:0] act,
                         input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act,
                             input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller raises start before calling; k counts edges from E (k=0).
    // mode 0: start high for 2 edges; 1: extra pulses every 5 cycles;
    // 2: start held high throughout.
    task automatic run_seq(input int mode, input int kmax, input string tag);
        int bends;
        int idx;
        bends = 0;
        idx   = 0;
        for (int k = 0; k <= kmax; k++) begin
            step();
            bends += int'(bus.BIST_END);
            if (idx < 12 && vecs[idx].k == k) begin
                check($sformatf("%s k=%0d", tag, k), outs(), vecs[idx].exp);
                idx++;
            end
            case (mode)
                0:       if (k >= 1) bus.start = 1'b0;
                1:       bus.start = (k < 65) && (k % 5 == 4);
                default: bus.start = 1'b1;
            endcase
        end
        check_int({tag, " bist_end count"}, bends, 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{0,  5'b00000};
        vecs[1]  = '{1,  5'b10000};
        vecs[2]  = '{16, 5'b10000};
        vecs[3]  = '{17, 5'b00010};
        vecs[4]  = '{18, 5'b10010};
        vecs[5]  = '{34, 5'b00100};
        vecs[6]  = '{35, 5'b10100};
        vecs[7]  = '{51, 5'b00110};
        vecs[8]  = '{67, 5'b10110};
        vecs[9]  = '{68, 5'b01110};
        vecs[10] = '{69, 5'b00111};
        vecs[11] = '{75, 5'b00111};

        rst       = 1'b1;
        bus.start = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset state", outs(), 5'b00000);
        step();
        check("idle no start", outs(), 5'b00000);

        // Basic full run.
        bus.start = 1'b1;
        run_seq(0, 75, "run1");

        // From DONE, restart with spurious pulses during the run.
        bus.start = 1'b1;
        run_seq(1, 75, "run2");

        // Mid-run reset aborts asynchronously.
        bus.start = 1'b1;
        for (int k = 0; k <= 39; k++) begin
            step();
            if (k >= 1) bus.start = 1'b0;
        end
        check("pre-abort", outs(), 5'b10100);
        #2 rst = 1'b1;
        #1 check("async abort", outs(), 5'b00000);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) step();
        check("idle after abort", outs(), 5'b00000);

        // Start held high: exactly one run, FINISH stays set.
        bus.start = 1'b1;
        run_seq(2, 129, "hold");
        check("hold finish", outs(), 5'b00111);

        // Reset with start high: release must not trigger.
        #2 rst = 1'b1;
        #1 check("rst while held", outs(), 5'b00000);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("no run after rst", outs(), 5'b00000);
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        check("fresh edge load", outs(), 5'b00000);
        step();
        check("fresh edge run", outs(), 5'b10000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
